// File: rtl/seq_divider_8bit_pkg.sv
// Shared widths, iteration count and FSM state encoding for the
// sequential restoring divider.
package seq_divider_8bit_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ITER_COUNT = 8;
  localparam int CNT_WIDTH  = 3;

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_8bit_cla.sv
// 8-bit carry-lookahead adder. The divider uses it as a subtractor:
// B is inverted and Cin is 1, so Cout=1 means no borrow.
module CLA_8bit
  import seq_divider_8bit_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  output logic [DATA_WIDTH-1:0] Sum,
  output logic                  Cout
);

  logic [DATA_WIDTH-1:0] w_gen;
  logic [DATA_WIDTH-1:0] w_prop;
  logic [DATA_WIDTH:0]   w_carry;

  assign w_gen  = A & B;
  assign w_prop = A ^ B;

  // Carries from generate/propagate terms; synthesis flattens the lookahead.
  always_comb begin
    w_carry    = '0;
    w_carry[0] = Cin;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      w_carry[i+1] = w_gen[i] | (w_prop[i] & w_carry[i]);
    end
  end

  assign Sum  = w_prop ^ w_carry[DATA_WIDTH-1:0];
  assign Cout = w_carry[DATA_WIDTH];

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per clock,
// eight iterations, results held after the one-cycle done pulse.
module seq_divider_8bit
  import seq_divider_8bit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  state_t                r_state;
  state_t                w_nextState;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_divisor;
  logic [CNT_WIDTH-1:0]  r_count;
  logic                  r_dbz;

  logic                  w_startAccept;
  logic                  w_shiftOut;
  logic [DATA_WIDTH-1:0] w_lowShift;
  logic [DATA_WIDTH-1:0] w_divisorInv;
  logic [DATA_WIDTH-1:0] w_trial;
  logic                  w_noBorrow;
  logic                  w_accept;

  assign w_startAccept = start & (r_state != RUN);

  // r_quo starts as the dividend; its MSB feeds the remainder while
  // quotient bits enter at the LSB, so after 8 steps it is the quotient.
  assign w_shiftOut   = r_rem[DATA_WIDTH-1];
  assign w_lowShift   = {r_rem[DATA_WIDTH-2:0], r_quo[DATA_WIDTH-1]};
  assign w_divisorInv = ~r_divisor;

  CLA_8bit u_trialSub (
    .A    (w_lowShift),
    .B    (w_divisorInv),
    .Cin  (1'b1),
    .Sum  (w_trial),
    .Cout (w_noBorrow)
  );

  assign w_accept = w_shiftOut | w_noBorrow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = RUN;
      RUN:     if (r_count == LAST_ITER) w_nextState = DONE;
      DONE:    w_nextState = start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo     <= '0;
      r_rem     <= '0;
      r_divisor <= '0;
      r_count   <= '0;
      r_dbz     <= 1'b0;
    end else if (w_startAccept) begin
      r_quo     <= dividend;
      r_rem     <= '0;
      r_divisor <= divisor;
      r_count   <= '0;
      r_dbz     <= (divisor == '0);
    end else if (r_state == RUN) begin
      r_quo   <= {r_quo[DATA_WIDTH-2:0], w_accept};
      r_rem   <= w_accept ? w_trial : w_lowShift;
      r_count <= r_count + 1'b1;
    end
  end

  assign busy        = (r_state == RUN);
  assign done        = (r_state == DONE);
  assign quotient    = r_quo;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench for seq_divider_8bit: directed cases plus random
// divides, compared every cycle against a cycle-count behavioural model.
module tb_seq_divider_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  seq_divider_8bit dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Model: edges left until the result appears, plus the result itself
  // computed with plain division when the operation is accepted.
  int         mLeft   = 0;
  bit         mDone   = 0;
  bit         mValid  = 0;
  bit         mKnown  = 0;
  logic [7:0] mQ, mR, pQ, pR;
  bit         mZ, pZ;

  always @(posedge clk) begin
    if (rst) begin
      mKnown = 1; mLeft = 0; mDone = 0; mValid = 1;
      mQ = 8'h00; mR = 8'h00; mZ = 0;
    end else if (mKnown) begin
      mDone = 0;
      if (start && mLeft == 0) begin
        mLeft  = 8;
        mValid = 0;
        if (divisor == 8'd0) begin
          pQ = 8'hFF; pR = dividend; pZ = 1;
        end else begin
          pQ = dividend / divisor; pR = dividend % divisor; pZ = 0;
        end
      end else if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) begin
          mDone = 1; mValid = 1;
          mQ = pQ; mR = pR; mZ = pZ;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mKnown) begin
      checkOutput("model_busy", int'(busy), int'(mLeft > 0));
      checkOutput("model_done", int'(done), int'(mDone));
      if (mValid) begin
        checkOutput("model_quotient", int'(quotient), int'(mQ));
        checkOutput("model_remainder", int'(remainder), int'(mR));
        checkOutput("model_dbz", int'(div_by_zero), int'(mZ));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done counting edges after the start edge; optionally pulses
  // a spurious start with random operands at a given RUN cycle.
  task automatic waitDone(input int pulseAt, output int lat);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == pulseAt && !done) begin
        start = 1'b1;
        dividend = 8'($urandom_range(0, 255));
        divisor  = 8'($urandom_range(0, 255));
      end else begin
        start = 1'b0;
      end
    end
    if (!done) begin
      checks++; fails++;
      $display("[TB] FAIL done_timeout: got done=%0d, expected 1 within 20 cycles", done);
    end
  endtask

  task automatic runOp(input logic [7:0] a, input logic [7:0] b,
                       input int expQ, input int expR, input int expZ, input int pulseAt);
    int lat;
    applyStimulus(a, b);
    waitDone(pulseAt, lat);
    checkOutput("latency", lat, 8);
    checkOutput("quotient", int'(quotient), expQ);
    checkOutput("remainder", int'(remainder), expR);
    checkOutput("div_by_zero", int'(div_by_zero), expZ);
  endtask

  initial begin
    int lat;
    logic [7:0] a, b;
    int eq, er, ez, pulse;

    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_quotient", int'(quotient), 0);
    checkOutput("reset_remainder", int'(remainder), 0);
    checkOutput("reset_dbz", int'(div_by_zero), 0);
    start = 1'b0; rst = 1'b0;

    runOp(8'd200, 8'd7, 28, 4, 0, -1);
    runOp(8'd255, 8'd255, 1, 0, 0, 3);
    runOp(8'd255, 8'd1, 255, 0, 0, -1);
    runOp(8'd5, 8'd9, 0, 5, 0, -1);
    runOp(8'hFF, 8'd0, 255, 255, 1, -1);

    // Back-to-back: restart in the done cycle, spurious starts during RUN.
    applyStimulus(8'd100, 8'd3);
    waitDone(2, lat);
    checkOutput("b2b_first_latency", lat, 8);
    checkOutput("b2b_first_quotient", int'(quotient), 33);
    checkOutput("b2b_first_remainder", int'(remainder), 1);
    start = 1'b1; dividend = 8'd17; divisor = 8'd4;
    @(negedge clk);
    start = 1'b0;
    checkOutput("b2b_no_idle_busy", int'(busy), 1);
    waitDone(5, lat);
    checkOutput("b2b_second_latency", lat, 8);
    checkOutput("b2b_second_quotient", int'(quotient), 4);
    checkOutput("b2b_second_remainder", int'(remainder), 1);

    // Reset landing on the 4th RUN edge aborts the divide.
    applyStimulus(8'd77, 8'd5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_quotient", int'(quotient), 0);
    checkOutput("abort_remainder", int'(remainder), 0);
    runOp(8'd9, 8'd2, 4, 1, 0, -1);

    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (b == 8'd0) begin
        eq = 255; er = int'(a); ez = 1;
      end else begin
        eq = int'(a) / int'(b); er = int'(a) % int'(b); ez = 0;
      end
      pulse = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : -1;
      runOp(a, b, eq, er, ez, pulse);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/seq_divider_8bit.md
SEQ_DIVIDER_8BIT -- requirements
Module: seq_divider_8bit

Interface
REQ-001 The block SHALL expose these ports, clock and reset first:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an unsigned divide.
- dividend  input  8  unsigned dividend, sampled when start is accepted.
- divisor  input  8  unsigned divisor, sampled when start is accepted.
- busy  output  1  high while iterations are in progress.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  8  unsigned quotient.
- remainder  output  8  unsigned remainder.
- div_by_zero  output  1  divisor sampled at start was 0.
REQ-002 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst.

Function
REQ-003 The block SHALL implement an FSM with three states: IDLE, RUN and DONE.
REQ-004 The block SHALL accept start only in IDLE or DONE, and SHALL ignore start in RUN.
REQ-005 On an accepted start at edge N, the block SHALL:
- latch dividend and divisor;
- clear the partial remainder;
- set div_by_zero = (divisor == 0);
- clear the iteration count;
- enter RUN.
REQ-006 Each RUN edge SHALL perform one restoring step:
- shift {partial remainder, next dividend MSB} left;
- trial = low 8 bits of the shifted value minus divisor;
- the step is accepted if the bit shifted out of the partial remainder is 1 or the subtraction produces no borrow;
- if accepted, the quotient bit is 1 and the partial remainder becomes trial;
- otherwise, the quotient bit is 0 and the shifted value is kept.
REQ-007 Exactly 8 iterations SHALL occur, at edges N+1..N+8, and the FSM SHALL enter DONE at edge N+8.
REQ-008 done SHALL be 1 for exactly the cycle between edges N+8 and N+9; the latency from the start edge to the done cycle is 8 clocks.
REQ-009 From DONE, the FSM SHALL go to RUN if start=1, else to IDLE; a start in DONE SHALL give back-to-back operation with no idle cycle.
REQ-010 busy SHALL equal (state == RUN).
REQ-011 quotient, remainder and div_by_zero SHALL be valid from the done cycle and held unchanged until the next accepted start; their values during RUN are unspecified.
REQ-012 Divisor 0 SHALL NOT be special-cased in the datapath: every step accepts, so the result is quotient=0xFF, remainder=dividend, div_by_zero=1, with normal latency.
REQ-013 All arithmetic SHALL be unsigned and 8 bits wide; no state SHALL need more than 8 bits except the 1-bit shift-out and the iteration counter.
REQ-014 rst=1 at any edge, including during RUN or DONE, SHALL abort the operation and apply the reset state; start in the same cycle as rst SHALL be ignored.

Reset
REQ-015 On reset the block SHALL set:
- state=IDLE, busy=0, done=0;
- quotient=0x00, remainder=0x00, div_by_zero=0;
- iteration counter=0 and all internal registers=0.
REQ-016 The block SHALL have no asynchronous reset path.

Structure
REQ-017 A shared package/include SHALL hold:
- DATA_WIDTH=8;
- ITER_COUNT=8;
- the state encoding constants IDLE/RUN/DONE.
REQ-018 The trial subtraction SHALL be one sub-module instance of the existing carry-lookahead adder, CLA_8bit, used as a subtractor:
- B input inverted, Cin=1;
- Cout=1 means no borrow.
REQ-019 The FSM, counter and shift registers SHALL live in seq_divider_8bit; no other sub-module SHALL be added.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- start, 200/7 -> done 8 clocks after the start edge; quotient=28, remainder=4, div_by_zero=0.
- start, 255/255 then 255/1 -> 1 r 0, then 255 r 0.
- start, 5/9 -> quotient=0, remainder=5.
- start, 0xFF/0 -> quotient=0xFF, remainder=0xFF, div_by_zero=1, same latency.
- 100/3 with start re-asserted in the done cycle with 17/4 -> 33 r 1, then 4 r 1, no idle gap; start pulses during RUN are ignored.
- rst asserted at the 4th RUN edge -> next cycle busy=0, done=0, quotient=remainder=0; a new 9/2 then gives 4 r 1.
